// File: rtl/game_event_sched_pkg.sv
// Shared types for the game event scheduler: user event codes, FSM states and event sources.
package game_event_sched_pkg;

  typedef enum logic [2:0] {
    EV_DOWN     = 3'd0,
    EV_ROTATE   = 3'd1,
    EV_LEFT     = 3'd2,
    EV_RIGHT    = 3'd3,
    EV_NEW_GAME = 3'd4
  } user_event_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } sched_state_t;

  typedef enum logic {
    SRC_USER    = 1'b0,
    SRC_GRAVITY = 1'b1
  } event_src_t;

  localparam logic [7:0] DROP_CNT_MAX = 8'hFF;

  // A manual drop or a fresh game restarts the gravity interval.
  function automatic logic restarts_gravity(input user_event_t ev);
    return (ev == EV_DOWN) || (ev == EV_NEW_GAME);
  endfunction

endpackage

// File: rtl/game_event_sched_gravity_timer.sv
// Level-scaled gravity timer with a single coalescing pending-tick flag.
// The flag rises the cycle after the counter reaches period-1 and holds until taken or cleared.
module game_event_sched_gravity_timer
  import game_event_sched_pkg::*;
#(
  parameter int GRAVITY_BASE = 25_000_000,
  parameter int GRAVITY_STEP = 1_500_000,
  parameter int GRAVITY_MIN  = 2_500_000,
  parameter int CNT_W        = 25
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] level_i,
  input  logic       active_i,
  input  logic       clear_i,
  input  logic       take_i,
  output logic       tick_pending_o
);

  localparam int PW = CNT_W + 5;
  localparam logic [CNT_W-1:0] PERIOD_M1_RST = CNT_W'(GRAVITY_BASE - 1);

  logic [PW-1:0]    dec;
  logic [PW-1:0]    period;
  logic [CNT_W-1:0] period_m1_d, period_m1_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             tick_pending_d, tick_pending_q;
  logic             wrap;

  // Compare before subtracting so high levels clamp to the floor instead of underflowing.
  always_comb begin
    dec = PW'(level_i) * PW'(GRAVITY_STEP);
    if (dec + PW'(GRAVITY_MIN) >= PW'(GRAVITY_BASE)) begin
      period = PW'(GRAVITY_MIN);
    end else begin
      period = PW'(GRAVITY_BASE) - dec;
    end
    period_m1_d = CNT_W'(period - PW'(1));
  end

  assign wrap = (cnt_q >= period_m1_q);

  always_comb begin
    cnt_d          = cnt_q + CNT_W'(1);
    tick_pending_d = tick_pending_q;
    if (!active_i || clear_i) begin
      cnt_d          = '0;
      tick_pending_d = 1'b0;
    end else begin
      if (take_i) begin
        tick_pending_d = 1'b0;
      end
      if (wrap) begin
        cnt_d          = '0;
        tick_pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      period_m1_q    <= PERIOD_M1_RST;
      cnt_q          <= '0;
      tick_pending_q <= 1'b0;
    end else begin
      period_m1_q    <= period_m1_d;
      cnt_q          <= cnt_d;
      tick_pending_q <= tick_pending_d;
    end
  end

  assign tick_pending_o = tick_pending_q;

endmodule

// File: rtl/game_event_sched.sv
// Round-robin scheduler feeding user FIFO events and gravity drops to game logic one at a time.
// User event valid 2 cycles after rdreq, gravity 2 cycles after the tick; each event held until done.
module game_event_sched
  import game_event_sched_pkg::*;
#(
  parameter int GRAVITY_BASE = 25_000_000,
  parameter int GRAVITY_STEP = 1_500_000,
  parameter int GRAVITY_MIN  = 2_500_000,
  parameter int CNT_W        = 25
) (
  input  logic        main_logic_clk_i,
  input  logic        rst_i,
  input  user_event_t user_event_i,
  input  logic        user_event_ready_i,
  output logic        user_event_rd_req_o,
  input  logic [3:0]  level_i,
  input  logic        game_active_i,
  output user_event_t event_o,
  output logic        event_src_o,
  output logic        event_valid_o,
  input  logic        event_done_i,
  output logic [7:0]  dropped_cnt_o
);

  sched_state_t state_q;
  user_event_t  event_q;
  event_src_t   src_q;
  event_src_t   last_src_q;
  logic         valid_q;
  logic [7:0]   dropped_q;

  logic tick_pending;
  logic grav_win;
  logic user_win;
  logic keep_user;
  logic take_tick;
  logic gravity_clear;

  // Each source wins a contention only if the other one went last.
  assign grav_win  = tick_pending && ((last_src_q == SRC_USER) || !user_event_ready_i);
  assign user_win  = user_event_ready_i && ((last_src_q == SRC_GRAVITY) || !tick_pending);
  assign keep_user = game_active_i || (user_event_i == EV_NEW_GAME);

  assign user_event_rd_req_o = (state_q == IDLE) && user_win;
  assign take_tick           = (state_q == IDLE) && grav_win;
  assign gravity_clear       = (state_q == FETCH) && keep_user && restarts_gravity(user_event_i);

  game_event_sched_gravity_timer #(
    .GRAVITY_BASE (GRAVITY_BASE),
    .GRAVITY_STEP (GRAVITY_STEP),
    .GRAVITY_MIN  (GRAVITY_MIN),
    .CNT_W        (CNT_W)
  ) u_gravity_timer (
    .clk_i          (main_logic_clk_i),
    .rst_i          (rst_i),
    .level_i        (level_i),
    .active_i       (game_active_i),
    .clear_i        (gravity_clear),
    .take_i         (take_tick),
    .tick_pending_o (tick_pending)
  );

  always_ff @(posedge main_logic_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      event_q    <= EV_DOWN;
      src_q      <= SRC_USER;
      last_src_q <= SRC_GRAVITY;
      valid_q    <= 1'b0;
      dropped_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grav_win) begin
            event_q <= EV_DOWN;
            src_q   <= SRC_GRAVITY;
            valid_q <= 1'b1;
            state_q <= ISSUE;
          end else if (user_win) begin
            state_q <= FETCH;
          end
        end
        FETCH: begin
          if (keep_user) begin
            event_q <= user_event_i;
            src_q   <= SRC_USER;
            valid_q <= 1'b1;
            state_q <= ISSUE;
          end else begin
            if (dropped_q != DROP_CNT_MAX) begin
              dropped_q <= dropped_q + 8'd1;
            end
            state_q <= IDLE;
          end
        end
        ISSUE: begin
          if (event_done_i) begin
            valid_q    <= 1'b0;
            last_src_q <= src_q;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign event_o       = event_q;
  assign event_src_o   = src_q;
  assign event_valid_o = valid_q;
  assign dropped_cnt_o = dropped_q;

endmodule

// File: tb/tb_game_event_sched.sv
// Bench for game_event_sched: period table, hand-written corner sequences and a random scoreboard run.
module tb_game_event_sched;
  import game_event_sched_pkg::*;

  localparam int BASE = 100;
  localparam int STEP = 10;
  localparam int MIN  = 20;

  logic        clk = 1'b0;
  logic        rst_i;
  user_event_t user_event_i;
  logic        user_event_ready_i;
  logic        user_event_rd_req_o;
  logic [3:0]  level_i;
  logic        game_active_i;
  user_event_t event_o;
  logic        event_src_o;
  logic        event_valid_o;
  logic        event_done_i;
  logic [7:0]  dropped_cnt_o;

  game_event_sched #(
    .GRAVITY_BASE (BASE),
    .GRAVITY_STEP (STEP),
    .GRAVITY_MIN  (MIN),
    .CNT_W        (25)
  ) dut (
    .main_logic_clk_i    (clk),
    .rst_i               (rst_i),
    .user_event_i        (user_event_i),
    .user_event_ready_i  (user_event_ready_i),
    .user_event_rd_req_o (user_event_rd_req_o),
    .level_i             (level_i),
    .game_active_i       (game_active_i),
    .event_o             (event_o),
    .event_src_o         (event_src_o),
    .event_valid_o       (event_valid_o),
    .event_done_i        (event_done_i),
    .dropped_cnt_o       (dropped_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] level;
    int         exp_first;
    int         exp_gap;
  } vec_t;

  vec_t        vecs[7];
  int          nchk = 0;
  int          nerr = 0;
  int          cyc = 0;
  user_event_t fifo[$];
  user_event_t exp_q[$];
  int          rise_cyc[$];
  logic        rise_src[$];
  user_event_t rise_ev[$];
  int          rd_cnt = 0;
  int          rd_cyc = -100;
  int          age = 0;
  int          done_dly = 0;
  logic        done_tie = 1'b0;
  logic        rand_dly = 1'b0;
  logic        prev_valid = 1'b0;
  user_event_t held_ev = EV_DOWN;
  logic        held_src = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: observe at the falling edge, drive just after the rising edge.
  task automatic step();
    logic pop;
    pop = 1'b0;
    @(negedge clk);
    if (user_event_rd_req_o) begin
      chk("rdreq_only_when_ready", int'(user_event_ready_i), 1);
      rd_cnt++;
      rd_cyc = cyc;
      pop = 1'b1;
    end
    if (event_valid_o && !prev_valid) begin
      rise_cyc.push_back(cyc);
      rise_src.push_back(event_src_o);
      rise_ev.push_back(event_o);
      held_ev  = event_o;
      held_src = event_src_o;
      if (event_src_o) begin
        chk("gravity_event_is_down", int'(event_o), int'(EV_DOWN));
      end else begin
        chk("user_valid_latency", cyc - rd_cyc, 2);
        chk("user_event_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("user_event_order", int'(event_o), int'(exp_q.pop_front()));
      end
    end else if (event_valid_o && prev_valid) begin
      chk("hold_event", int'(event_o), int'(held_ev));
      chk("hold_src", int'(event_src_o), int'(held_src));
    end
    prev_valid = event_valid_o;
    @(posedge clk);
    #1;
    cyc++;
    if (pop && fifo.size() != 0) user_event_i = fifo.pop_front();
    user_event_ready_i = (fifo.size() != 0);
    if (event_valid_o) age++;
    else age = 0;
    if (rand_dly && age == 1) done_dly = $urandom_range(0, 4);
    event_done_i = done_tie || (event_valid_o && age > done_dly);
  endtask

  task automatic push(input user_event_t ev, input logic expect_issue);
    fifo.push_back(ev);
    if (expect_issue) exp_q.push_back(ev);
    user_event_ready_i = 1'b1;
  endtask

  task automatic clear_logs();
    rise_cyc.delete();
    rise_src.delete();
    rise_ev.delete();
    rd_cnt = 0;
  endtask

  task automatic wait_rises(input int n, input int budget, input string name, output logic ok);
    int k;
    k = 0;
    while (rise_cyc.size() < n && k < budget) begin
      step();
      k++;
    end
    chk({name, "_valid_count"}, rise_cyc.size(), n);
    ok = (rise_cyc.size() >= n);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    game_active_i = 1'b0;
    fifo.delete();
    exp_q.delete();
    user_event_ready_i = 1'b0;
    done_tie = 1'b0;
    rand_dly = 1'b0;
    done_dly = 0;
    repeat (3) step();
    chk("reset_valid", int'(event_valid_o), 0);
    chk("reset_rdreq", int'(user_event_rd_req_o), 0);
    chk("reset_event", int'(event_o), int'(EV_DOWN));
    chk("reset_src", int'(event_src_o), 0);
    chk("reset_dropped", int'(dropped_cnt_o), 0);
    rst_i = 1'b0;
    step();
    step();
    clear_logs();
  endtask

  initial begin
    logic ok;
    int   c0;
    int   n_push;
    int   n_user;
    int   n_grav;
    int   k;

    rst_i = 1'b1;
    level_i = 4'd0;
    game_active_i = 1'b0;
    event_done_i = 1'b0;
    user_event_i = EV_DOWN;
    user_event_ready_i = 1'b0;

    vecs[0] = '{4'd0,  101, 100};
    vecs[1] = '{4'd3,  71,  70};
    vecs[2] = '{4'd5,  51,  50};
    vecs[3] = '{4'd7,  31,  30};
    vecs[4] = '{4'd8,  21,  20};
    vecs[5] = '{4'd12, 21,  20};
    vecs[6] = '{4'd15, 21,  20};

    // Gravity period per level, done tied high throughout.
    do_reset();
    done_tie = 1'b1;
    for (int i = 0; i < 7; i++) begin
      game_active_i = 1'b0;
      level_i = vecs[i].level;
      repeat (3) step();
      clear_logs();
      game_active_i = 1'b1;
      c0 = cyc;
      wait_rises(2, 2 * vecs[i].exp_gap + 20, "period", ok);
      if (ok) begin
        chk("period_first_valid", rise_cyc[0] - c0, vecs[i].exp_first);
        chk("period_gap", rise_cyc[1] - rise_cyc[0], vecs[i].exp_gap);
        chk("period_src_gravity", int'(rise_src[0]), 1);
      end
    end

    // Preloaded FIFO drains in order with three read pulses.
    level_i = 4'd0;
    do_reset();
    done_dly = 2;
    push(EV_LEFT, 1'b1);
    push(EV_RIGHT, 1'b1);
    push(EV_ROTATE, 1'b1);
    game_active_i = 1'b1;
    repeat (40) step();
    chk("fifo_rdreq_pulses", rd_cnt, 3);
    chk("fifo_valid_count", rise_cyc.size(), 3);
    if (rise_cyc.size() == 3) begin
      chk("fifo_ev0", int'(rise_ev[0]), int'(EV_LEFT));
      chk("fifo_ev1", int'(rise_ev[1]), int'(EV_RIGHT));
      chk("fifo_ev2", int'(rise_ev[2]), int'(EV_ROTATE));
      for (int i = 0; i < 3; i++) chk("fifo_src_user", int'(rise_src[i]), 0);
    end

    // Contention alternates, first contention after reset goes to the user.
    level_i = 4'd15;
    do_reset();
    done_dly = 25;
    game_active_i = 1'b1;
    repeat (20) step();
    push(EV_LEFT, 1'b1);
    push(EV_RIGHT, 1'b1);
    push(EV_ROTATE, 1'b1);
    push(EV_LEFT, 1'b1);
    wait_rises(8, 400, "alternate", ok);
    if (ok) begin
      for (int i = 0; i < 8; i++) chk("alternate_src", int'(rise_src[i]), i % 2);
    end

    // Level jump from 0 to 15 with the counter at 50.
    level_i = 4'd0;
    do_reset();
    done_tie = 1'b1;
    game_active_i = 1'b1;
    c0 = cyc;
    repeat (50) step();
    level_i = 4'd15;
    wait_rises(2, 100, "level_jump", ok);
    if (ok) begin
      chk("level_jump_first", rise_cyc[0] - c0, 53);
      chk("level_jump_second", rise_cyc[1] - c0, 73);
    end

    // A user drop at counter 90 restarts the gravity interval.
    level_i = 4'd0;
    do_reset();
    game_active_i = 1'b1;
    c0 = cyc;
    repeat (88) step();
    push(EV_DOWN, 1'b1);
    wait_rises(2, 300, "manual_drop", ok);
    if (ok) begin
      chk("manual_drop_src", int'(rise_src[0]), 0);
      chk("manual_drop_at", rise_cyc[0] - c0, 90);
      chk("manual_drop_next_src", int'(rise_src[1]), 1);
      chk("manual_drop_next_gap", rise_cyc[1] - rise_cyc[0], BASE + 1);
    end

    // Game inactive: only NEW_GAME passes, drops saturate at 255.
    do_reset();
    push(EV_LEFT, 1'b0);
    push(EV_NEW_GAME, 1'b1);
    repeat (300) step();
    chk("inactive_dropped", int'(dropped_cnt_o), 1);
    chk("inactive_valid_count", rise_cyc.size(), 1);
    if (rise_cyc.size() == 1) begin
      chk("inactive_src", int'(rise_src[0]), 0);
      chk("inactive_event", int'(rise_ev[0]), int'(EV_NEW_GAME));
    end
    for (int i = 0; i < 300; i++) push(EV_LEFT, 1'b0);
    repeat (700) step();
    chk("drop_saturate", int'(dropped_cnt_o), 255);
    chk("drop_no_issue", rise_cyc.size(), 1);
    chk("drop_fifo_empty", fifo.size(), 0);

    // Asynchronous reset in the middle of a held event.
    clear_logs();
    game_active_i = 1'b1;
    done_dly = 1000;
    push(EV_RIGHT, 1'b1);
    wait_rises(1, 20, "async_reset", ok);
    step();
    step();
    chk("pre_reset_valid", int'(event_valid_o), 1);
    chk("pre_reset_event", int'(event_o), int'(EV_RIGHT));
    chk("pre_reset_dropped", int'(dropped_cnt_o), 255);
    #2;
    rst_i = 1'b1;
    #1;
    chk("async_reset_valid", int'(event_valid_o), 0);
    chk("async_reset_rdreq", int'(user_event_rd_req_o), 0);
    chk("async_reset_event", int'(event_o), int'(EV_DOWN));
    chk("async_reset_src", int'(event_src_o), 0);
    chk("async_reset_dropped", int'(dropped_cnt_o), 0);
    step();
    step();
    rst_i = 1'b0;

    // Random traffic against the ordering scoreboard.
    level_i = 4'd0;
    do_reset();
    rand_dly = 1'b1;
    game_active_i = 1'b1;
    n_push = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) level_i = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) begin
        push(user_event_t'(3'($urandom_range(0, 4))), 1'b1);
        n_push++;
      end
      step();
    end
    k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      step();
      k++;
    end
    repeat (10) step();
    chk("random_drained", exp_q.size(), 0);
    n_user = 0;
    n_grav = 0;
    foreach (rise_src[i]) begin
      if (rise_src[i]) n_grav++;
      else n_user++;
    end
    chk("random_user_count", n_user, n_push);
    chk("random_gravity_seen", int'(n_grav > 0), 1);
    chk("random_rdreq_count", rd_cnt, n_push);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
